// File: rtl/lcd_init_ctrl.sv
// lcd_init_ctrl: power-on init sequencer and byte writer for a 4-bit HD44780-style LCD.
// Waits are timed by an external counter that is restarted through timer_clr.
module lcd_init_ctrl #(
  parameter int unsigned E_CYCLES   = 12,
  parameter int unsigned GAP_CYCLES = 50,
  parameter int unsigned PWR_MS     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       time_1ms,
  input  logic       time_100us,
  input  logic       time_40us,
  output logic       timer_clr,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);
  localparam int unsigned CNT_MAX  = (E_CYCLES > GAP_CYCLES) ? E_CYCLES : GAP_CYCLES;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam int unsigned WAIT_MAX = (PWR_MS > 5) ? PWR_MS : 5;
  localparam int unsigned MW       = $clog2(WAIT_MAX + 1);
  localparam logic [3:0]  STEP_LAST = 4'd8;

  typedef enum logic [2:0] {PWR_WAIT, NIB_SETUP, NIB_E, NIB_HOLD, GAP, WAIT, IDLE} state_t;
  typedef enum logic [1:0] {SEL_1MS, SEL_100US, SEL_40US} sel_t;

  state_t        state, state_n;
  sel_t          wait_sel, wait_sel_n, item_sel;
  logic [1:0]    ign, ign_n;
  logic [MW-1:0] ms_cnt, ms_cnt_n, wait_num, wait_num_n, item_num;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    step, step_n;
  logic [7:0]    data, data_n, item_data;
  logic          rs, rs_n, is_byte, is_byte_n, lower, lower_n, done, done_n;
  logic          item_byte, clr, flag, nib_active, host_long;

  // Init script: what to write for each step and which wait follows it.
  // Single init nibbles are stored in the upper half of data and sent as an upper nibble.
  always_comb begin
    item_byte = 1'b1;
    item_data = 8'h00;
    item_sel  = SEL_40US;
    item_num  = MW'(1);
    case (step)
      4'd0: begin item_byte = 1'b0; item_data = 8'h30; item_sel = SEL_1MS; item_num = MW'(5); end
      4'd1: begin item_byte = 1'b0; item_data = 8'h30; item_sel = SEL_100US; end
      4'd2: begin item_byte = 1'b0; item_data = 8'h30; end
      4'd3: begin item_byte = 1'b0; item_data = 8'h20; end
      4'd4: item_data = 8'h28;
      4'd5: item_data = 8'h06;
      4'd6: item_data = 8'h0C;
      4'd7: begin item_data = 8'h01; item_sel = SEL_1MS; item_num = MW'(2); end
      default: ;
    endcase
  end

  // Select the counter flag the current wait is waiting for.
  always_comb begin
    case (wait_sel)
      SEL_1MS:   flag = time_1ms;
      SEL_100US: flag = time_100us;
      default:   flag = time_40us;
    endcase
  end

  assign host_long = !cmd_rs && (cmd_data == 8'h01 || cmd_data == 8'h02);

  // Next-state logic. In a wait, ign counts the clear cycle and the following
  // cycle, during which the (registered) counter flags are still stale.
  always_comb begin
    state_n    = state;
    ign_n      = ign;
    ms_cnt_n   = ms_cnt;
    wait_sel_n = wait_sel;
    wait_num_n = wait_num;
    cnt_n      = cnt;
    step_n     = step;
    data_n     = data;
    rs_n       = rs;
    is_byte_n  = is_byte;
    lower_n    = lower;
    done_n     = done;
    clr        = 1'b0;
    case (state)
      PWR_WAIT, WAIT: begin
        clr = (ign == 2'd0);
        if (ign != 2'd2) begin
          ign_n = ign + 2'd1;
        end else if (flag) begin
          ign_n = '0;
          if (ms_cnt != wait_num - MW'(1)) begin
            ms_cnt_n = ms_cnt + MW'(1);
          end else if (step == STEP_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n    = NIB_SETUP;
            data_n     = item_data;
            rs_n       = 1'b0;
            is_byte_n  = item_byte;
            lower_n    = 1'b0;
            wait_sel_n = item_sel;
            wait_num_n = item_num;
            step_n     = step + 4'd1;
          end
        end
      end
      NIB_SETUP: begin
        state_n = NIB_E;
        cnt_n   = CW'(E_CYCLES - 1);
      end
      NIB_E: begin
        if (cnt == '0) state_n = NIB_HOLD;
        else cnt_n = cnt - CW'(1);
      end
      NIB_HOLD: begin
        if (is_byte && !lower) begin
          state_n = GAP;
          cnt_n   = CW'(GAP_CYCLES - 1);
        end else begin
          state_n  = WAIT;
          ign_n    = '0;
          ms_cnt_n = '0;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = NIB_SETUP;
          lower_n = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      IDLE: begin
        if (cmd_valid) begin
          state_n    = NIB_SETUP;
          data_n     = cmd_data;
          rs_n       = cmd_rs;
          is_byte_n  = 1'b1;
          lower_n    = 1'b0;
          wait_sel_n = host_long ? SEL_1MS : SEL_40US;
          wait_num_n = host_long ? MW'(2) : MW'(1);
        end
      end
      default: state_n = PWR_WAIT;
    endcase
  end

  // State and datapath registers; reset restarts the power-on wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PWR_WAIT;
      wait_sel <= SEL_1MS;
      wait_num <= MW'(PWR_MS);
      ign      <= '0;
      ms_cnt   <= '0;
      cnt      <= '0;
      step     <= '0;
      data     <= '0;
      rs       <= 1'b0;
      is_byte  <= 1'b0;
      lower    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      wait_sel <= wait_sel_n;
      wait_num <= wait_num_n;
      ign      <= ign_n;
      ms_cnt   <= ms_cnt_n;
      cnt      <= cnt_n;
      step     <= step_n;
      data     <= data_n;
      rs       <= rs_n;
      is_byte  <= is_byte_n;
      lower    <= lower_n;
      done     <= done_n;
    end
  end

  assign nib_active = (state == NIB_SETUP) || (state == NIB_E) || (state == NIB_HOLD);
  assign lcd_e      = (state == NIB_E);
  assign lcd_d      = nib_active ? (lower ? data[3:0] : data[7:4]) : '0;
  assign lcd_rs     = nib_active & rs;
  assign lcd_rw     = 1'b0;
  assign cmd_ready  = (state == IDLE);
  assign init_done  = done;
  // Held low during reset so every output reads 0 while reset is asserted.
  assign timer_clr  = clr & ~reset;

endmodule
